// File: rtl/vga_frame_monitor.sv
// vga_frame_monitor: passive VGA stream checker.
// Measures line/frame geometry, CRCs active pixels, tracks lock.
module vga_frame_monitor #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_TOTAL  = 800,
  parameter int   V_ACTIVE = 480,
  parameter int   V_TOTAL  = 525,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_ce,
  input  logic        vga_hs,
  input  logic        vga_vs,
  input  logic        vga_blank_n,
  input  logic [7:0]  vga_r,
  input  logic [7:0]  vga_g,
  input  logic [7:0]  vga_b,
  output logic        frame_valid,
  output logic [15:0] frame_crc,
  output logic [10:0] h_total_meas,
  output logic [10:0] h_active_meas,
  output logic [10:0] v_total_meas,
  output logic [10:0] v_active_meas,
  output logic [15:0] frame_count,
  output logic        locked,
  output logic        err_timing
);

  typedef enum logic [1:0] {
    SEEK,
    MEASURE,
    CLOSE
  } state_t;

  localparam logic [10:0] HT = 11'(H_TOTAL);
  localparam logic [10:0] HA = 11'(H_ACTIVE);
  localparam logic [10:0] VT = 11'(V_TOTAL);
  localparam logic [10:0] VA = 11'(V_ACTIVE);

  state_t      state, state_n;
  logic        hs_a, vs_a;
  logic        hs_prev, vs_prev;
  logic        hs_edge, vs_edge;
  logic        close;
  logic        match;
  logic        prev_match;
  logic        ever_locked;

  logic [10:0] h_cnt, h_act_cnt, v_cnt, v_act_cnt;
  logic [10:0] line_tot, line_act;
  logic [15:0] crc;

  logic [10:0] h_n, ha_n, v_n, va_n, lt_n, la_n;
  logic [10:0] h_i, ha_i;
  logic [15:0] crc_n;

  function automatic logic [10:0] sat_inc(input logic [10:0] v);
    return (v == 11'h7FF) ? v : v + 11'd1;
  endfunction

  function automatic logic [15:0] crc24(
    input logic [15:0] c_in,
    input logic [23:0] d
  );
    logic [15:0] c;
    logic        fb;
    c = c_in;
    for (int i = 23; i >= 0; i--) begin
      fb = c[15] ^ d[i];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h1021;
    end
    return c;
  endfunction

  assign hs_a    = (vga_hs == SYNC_POL);
  assign vs_a    = (vga_vs == SYNC_POL);
  assign hs_edge = pix_ce & hs_a & ~hs_prev;
  assign vs_edge = pix_ce & vs_a & ~vs_prev;

  // CLOSE is the single clk in which the freshly latched results are presented
  assign frame_valid = (state == CLOSE);
  assign close       = (state == MEASURE) & vs_edge;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= SEEK;
    else       state <= state_n;
  end

  // Next-state: frame boundaries are vs leading edges
  always_comb begin
    state_n = state;
    unique case (state)
      SEEK:    if (vs_edge) state_n = MEASURE;
      MEASURE: if (vs_edge) state_n = CLOSE;
      CLOSE:   state_n = MEASURE;
      default: state_n = SEEK;
    endcase
  end

  // Apply the current sample: line close first, so a coincident frame close sees it
  always_comb begin
    h_n   = h_cnt;
    ha_n  = h_act_cnt;
    v_n   = v_cnt;
    va_n  = v_act_cnt;
    lt_n  = line_tot;
    la_n  = line_act;
    crc_n = crc;
    h_i   = sat_inc(h_cnt);
    ha_i  = vga_blank_n ? sat_inc(h_act_cnt) : h_act_cnt;
    if (pix_ce && state != SEEK) begin
      if (vga_blank_n) crc_n = crc24(crc, {vga_r, vga_g, vga_b});
      if (hs_edge) begin
        lt_n = h_i;
        la_n = ha_i;
        v_n  = sat_inc(v_cnt);
        if (ha_i != 11'd0) va_n = sat_inc(v_act_cnt);
        h_n  = 11'd0;
        ha_n = 11'd0;
      end else begin
        h_n  = h_i;
        ha_n = ha_i;
      end
    end
    match = (lt_n == HT) && (la_n == HA) && (v_n == VT) && (va_n == VA);
  end

  // Counters, result latching and lock tracking
  always_ff @(posedge clk) begin
    if (reset) begin
      hs_prev       <= 1'b0;
      vs_prev       <= 1'b0;
      h_cnt         <= '0;
      h_act_cnt     <= '0;
      v_cnt         <= '0;
      v_act_cnt     <= '0;
      line_tot      <= '0;
      line_act      <= '0;
      crc           <= '0;
      frame_crc     <= '0;
      h_total_meas  <= '0;
      h_active_meas <= '0;
      v_total_meas  <= '0;
      v_active_meas <= '0;
      frame_count   <= '0;
      locked        <= 1'b0;
      err_timing    <= 1'b0;
      prev_match    <= 1'b0;
      ever_locked   <= 1'b0;
    end else begin
      if (pix_ce) begin
        hs_prev <= hs_a;
        vs_prev <= vs_a;
      end
      if (state == SEEK || close) begin
        if (state == SEEK && !vs_edge) begin
          crc <= crc;
        end else begin
          h_cnt     <= '0;
          h_act_cnt <= '0;
          v_cnt     <= '0;
          v_act_cnt <= '0;
          line_tot  <= '0;
          line_act  <= '0;
          crc       <= 16'hFFFF;
        end
        if (close) begin
          frame_crc     <= crc_n;
          h_total_meas  <= lt_n;
          h_active_meas <= la_n;
          v_total_meas  <= v_n;
          v_active_meas <= va_n;
          frame_count   <= frame_count + 16'd1;
          locked        <= match & prev_match;
          prev_match    <= match;
          if (match && prev_match) ever_locked <= 1'b1;
          if (!match && ever_locked) err_timing <= 1'b1;
        end
      end else begin
        h_cnt     <= h_n;
        h_act_cnt <= ha_n;
        v_cnt     <= v_n;
        v_act_cnt <= va_n;
        line_tot  <= lt_n;
        line_act  <= la_n;
        crc       <= crc_n;
      end
    end
  end

endmodule

// File: tb/tb_vga_frame_monitor.sv
// tb_vga_frame_monitor: directed checks on a scaled-down
// 12x6 raster (8x4 active), pix_ce every second clk.
module tb_vga_frame_monitor;

  localparam int   HT = 12;
  localparam int   HA = 8;
  localparam int   VT = 6;
  localparam int   VA = 4;
  localparam logic SP = 1'b0;

  logic        clk = 1'b0;
  logic        reset;
  logic        pix_ce;
  logic        vga_hs, vga_vs, vga_blank_n;
  logic [7:0]  vga_r, vga_g, vga_b;
  logic        frame_valid;
  logic [15:0] frame_crc;
  logic [10:0] h_total_meas, h_active_meas;
  logic [10:0] v_total_meas, v_active_meas;
  logic [15:0] frame_count;
  logic        locked, err_timing;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int fv_hi  = 0;
  logic fv_q = 1'b0;

  logic [15:0] s_crc, s_cnt, crc_first;
  logic [10:0] s_ht, s_ha, s_vt, s_va;
  logic        s_lock, s_err;

  vga_frame_monitor #(
    .H_ACTIVE(HA), .H_TOTAL(HT),
    .V_ACTIVE(VA), .V_TOTAL(VT),
    .SYNC_POL(SP)
  ) dut (
    .clk(clk), .reset(reset), .pix_ce(pix_ce),
    .vga_hs(vga_hs), .vga_vs(vga_vs),
    .vga_blank_n(vga_blank_n),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .frame_valid(frame_valid), .frame_crc(frame_crc),
    .h_total_meas(h_total_meas),
    .h_active_meas(h_active_meas),
    .v_total_meas(v_total_meas),
    .v_active_meas(v_active_meas),
    .frame_count(frame_count),
    .locked(locked), .err_timing(err_timing)
  );

  always #5 clk = ~clk;

  // Count pulses and snapshot results away from the active edge
  always @(negedge clk) begin
    if (frame_valid) begin
      fv_hi = fv_hi + 1;
      if (!fv_q) begin
        pulses = pulses + 1;
        s_crc  = frame_crc;
        s_ht   = h_total_meas;
        s_ha   = h_active_meas;
        s_vt   = v_total_meas;
        s_va   = v_active_meas;
        s_cnt  = frame_count;
        s_lock = locked;
        s_err  = err_timing;
      end
    end
    fv_q = frame_valid;
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pix(input logic hs, input logic vs,
                     input logic bl, input logic [23:0] rgb);
    vga_hs      = hs ? SP : ~SP;
    vga_vs      = vs ? SP : ~SP;
    vga_blank_n = bl;
    {vga_r, vga_g, vga_b} = rgb;
    pix_ce = 1'b1;
    @(posedge clk); #1;
    pix_ce = 1'b0;
    @(posedge clk); #1;
  endtask

  // Frame starts with coincident hs/vs edges; extra samples stretch the last line
  task automatic send_frame(input int flip, input int extra,
                            input int nlines);
    int xn;
    logic act;
    logic [23:0] rgb;
    for (int y = 0; y < nlines; y++) begin
      xn = (y == VT - 1) ? HT + extra : HT;
      for (int x = 0; x < xn; x++) begin
        act = (y >= 2) && (y < 2 + VA) && (x >= 2) && (x < 2 + HA);
        rgb = (flip != 0 && y == 2 && x == 2) ? 24'h800000 : 24'h0;
        pix(x < 2, y < 2, act, rgb);
      end
    end
  endtask

  // Byte-wise CCITT reference over the 32 active pixels
  function automatic logic [15:0] model_crc(input int flip);
    logic [15:0] c;
    logic [23:0] px;
    logic [7:0]  bt;
    c = 16'hFFFF;
    for (int p = 0; p < HA * VA; p++) begin
      px = (flip != 0 && p == 0) ? 24'h800000 : 24'h0;
      for (int k = 0; k < 3; k++) begin
        bt = px[23 - 8 * k -: 8];
        c  = c ^ {bt, 8'h00};
        for (int j = 0; j < 8; j++)
          c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
      end
    end
    return c;
  endfunction

  task automatic check_geom(input string tag, input int ht);
    check({tag, "_htot"}, 32'(s_ht), 32'(ht));
    check({tag, "_hact"}, 32'(s_ha), HA);
    check({tag, "_vtot"}, 32'(s_vt), VT);
    check({tag, "_vact"}, 32'(s_va), VA);
  endtask

  initial begin
    reset = 1'b1;
    pix_ce = 1'b0;
    vga_hs = ~SP;
    vga_vs = ~SP;
    vga_blank_n = 1'b0;
    {vga_r, vga_g, vga_b} = 24'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_fv", 32'(frame_valid), 0);
    check("rst_cnt", 32'(frame_count), 0);
    check("rst_lock", 32'(locked), 0);
    check("rst_crc", 32'(frame_crc), 0);
    reset = 1'b0;

    send_frame(0, 0, VT);
    check("f1_nopulse", pulses, 0);
    send_frame(0, 0, VT);
    check("f2_pulses", pulses, 1);
    check_geom("f1", HT);
    check("f1_crc", 32'(s_crc), 32'(model_crc(0)));
    check("f1_lock", 32'(s_lock), 0);
    check("f1_err", 32'(s_err), 0);
    check("f1_cnt", 32'(s_cnt), 1);
    crc_first = s_crc;

    send_frame(0, 0, VT);
    check("f3_pulses", pulses, 2);
    check("f2_lock", 32'(s_lock), 1);
    check("f2_crc_same", 32'(s_crc), 32'(crc_first));

    send_frame(1, 0, VT);
    check("f4_pulses", pulses, 3);
    check("f3_cnt", 32'(s_cnt), 3);

    send_frame(0, 1, VT);
    check("f4_crc", 32'(s_crc), 32'(model_crc(1)));
    check("f4_crc_diff", 32'(s_crc != crc_first), 1);
    check_geom("f4", HT);
    check("f4_lock", 32'(s_lock), 1);

    send_frame(0, 0, VT);
    check("f5_htot", 32'(s_ht), HT + 1);
    check("f5_lock", 32'(s_lock), 0);
    check("f5_err", 32'(s_err), 1);

    send_frame(0, 0, VT);
    check("f6_lock", 32'(s_lock), 0);
    check("f6_err", 32'(s_err), 1);

    send_frame(0, 0, VT);
    check("f7_lock", 32'(s_lock), 1);
    check("f7_err", 32'(s_err), 1);
    check("f7_cnt", 32'(s_cnt), 7);

    send_frame(0, 0, 3);
    check("f8_pulses", pulses, 8);
    reset = 1'b1;
    @(posedge clk); #1;
    check("mrst_fv", 32'(frame_valid), 0);
    check("mrst_cnt", 32'(frame_count), 0);
    check("mrst_lock", 32'(locked), 0);
    check("mrst_err", 32'(err_timing), 0);
    check("mrst_htot", 32'(h_total_meas), 0);
    check("mrst_vtot", 32'(v_total_meas), 0);
    check("mrst_crc", 32'(frame_crc), 0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("mrst_pulses", pulses, 8);

    send_frame(0, 0, VT);
    check("a_nopulse", pulses, 8);
    send_frame(0, 0, VT);
    check("b_pulses", pulses, 9);
    check("a_cnt", 32'(s_cnt), 1);
    check("a_lock", 32'(s_lock), 0);

    send_frame(0, 3000, VT);
    check("c_pulses", pulses, 10);
    check("b_lock", 32'(s_lock), 1);

    send_frame(0, 0, VT);
    check("d_pulses", pulses, 11);
    check("c_htot_sat", 32'(s_ht), 2047);
    check("c_hact", 32'(s_ha), HA);
    check("c_lock", 32'(s_lock), 0);
    check("c_err", 32'(s_err), 1);
    check("c_cnt", 32'(s_cnt), 3);

    check("pulse_width", fv_hi, pulses);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
